// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared sizes, matrix types and state encoding for the matmul engine
package matmul_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int BUS_WIDTH  = 64;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W      = $clog2(MAX_DIM);
  localparam int IDX_W      = $clog2(MAX_DIM * MAX_DIM);

  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matA;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matB;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][BUS_WIDTH-1:0]  matC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CLK_NS  = 10;
  localparam int RST_CYC = 3;
endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - combinational signed multiply-accumulate step with overflow detect
module matmul_mac
  import matmul_pkg::*;
(
  input  logic [BUS_WIDTH-1:0]  acc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [BUS_WIDTH-1:0]  sum,
  output logic                  ovf
);
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [BUS_WIDTH-1:0]    prod_ext;

  always_comb begin
    prod     = $signed(a) * $signed(b);
    prod_ext = BUS_WIDTH'(prod);
    sum      = acc + prod_ext;
    // Overflow only when both addends share a sign and the wrapped sum flips it.
    ovf      = (acc[BUS_WIDTH-1] == prod_ext[BUS_WIDTH-1]) &&
               (sum[BUS_WIDTH-1] != acc[BUS_WIDTH-1]);
  end
endmodule

// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - sequential C = A*B (+C0) engine, one MAC per cycle, i/j/k loop order
module matmul_engine
  import matmul_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          acc_mode_i,
  input  logic [DIM_W-1:0]              dim_n_i,
  input  logic [DIM_W-1:0]              dim_k_i,
  input  logic [DIM_W-1:0]              dim_m_i,
  input  matA                           mat_a_i,
  input  matB                           mat_b_i,
  input  matC                           mat_c_i,
  output logic                          busy_o,
  output logic                          done_o,
  output matC                           mat_c_o,
  output logic [MAX_DIM*MAX_DIM-1:0]    ovf_o
);
  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_CALC = 2'(CALC);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]           state;
  matA                  a_q;
  matB                  b_q;
  matC                  c0_q;
  logic [DIM_W-1:0]     dn_q, dk_q, dm_q;
  logic                 mode_q;
  logic [DIM_W-1:0]     cnt_i, cnt_j, cnt_k;
  logic [BUS_WIDTH-1:0] acc_q;

  logic                 last_i, last_j, last_k;
  logic [DIM_W-1:0]     next_i, next_j;
  logic [IDX_W-1:0]     el_idx;
  logic [BUS_WIDTH-1:0] next_bias;
  logic [BUS_WIDTH-1:0] mac_sum;
  logic                 mac_ovf;

  matmul_mac u_mac (
    .acc (acc_q),
    .a   (a_q[cnt_i][cnt_k]),
    .b   (b_q[cnt_k][cnt_j]),
    .sum (mac_sum),
    .ovf (mac_ovf)
  );

  always_comb begin
    last_i    = (cnt_i == dn_q);
    last_j    = (cnt_j == dm_q);
    last_k    = (cnt_k == dk_q);
    next_j    = last_j ? '0 : cnt_j + 1'b1;
    next_i    = last_j ? cnt_i + 1'b1 : cnt_i;
    el_idx    = IDX_W'(int'(cnt_i) * MAX_DIM + int'(cnt_j));
    // Index wraps harmlessly after the final element; the job ends there anyway.
    next_bias = mode_q ? c0_q[next_i][next_j] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c0_q    <= '0;
      dn_q    <= '0;
      dk_q    <= '0;
      dm_q    <= '0;
      mode_q  <= 1'b0;
      cnt_i   <= '0;
      cnt_j   <= '0;
      cnt_k   <= '0;
      acc_q   <= '0;
      mat_c_o <= '0;
      ovf_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            a_q     <= mat_a_i;
            b_q     <= mat_b_i;
            c0_q    <= mat_c_i;
            dn_q    <= dim_n_i;
            dk_q    <= dim_k_i;
            dm_q    <= dim_m_i;
            mode_q  <= acc_mode_i;
            cnt_i   <= '0;
            cnt_j   <= '0;
            cnt_k   <= '0;
            acc_q   <= acc_mode_i ? mat_c_i[0][0] : '0;
            mat_c_o <= '0;
            ovf_o   <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          if (mac_ovf) ovf_o[el_idx] <= 1'b1;
          if (!last_k) begin
            acc_q <= mac_sum;
            cnt_k <= cnt_k + 1'b1;
          end else begin
            mat_c_o[cnt_i][cnt_j] <= mac_sum;
            cnt_k <= '0;
            cnt_j <= next_j;
            cnt_i <= next_i;
            acc_q <= next_bias;
            if (last_i && last_j) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);
endmodule

// File: tb/tb_matmul_engine.sv
// tb/tb_matmul_engine.sv - randomized self-checking bench for matmul_engine against a arithmetic model
module tb_matmul_engine;
  import matmul_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       start = 1'b0;
  logic                       acc_mode = 1'b0;
  logic [DIM_W-1:0]           dn = '0, dk = '0, dm = '0;
  matA                        a_in = '0;
  matB                        b_in = '0;
  matC                        c0_in = '0;
  logic                       busy, done;
  matC                        c_out;
  logic [MAX_DIM*MAX_DIM-1:0] ovf;

  int  total = 0;
  int  bad = 0;
  matC exp_c;
  logic [MAX_DIM*MAX_DIM-1:0] exp_ovf;

  matmul_engine dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .acc_mode_i (acc_mode),
    .dim_n_i    (dn),
    .dim_k_i    (dk),
    .dim_m_i    (dm),
    .mat_a_i    (a_in),
    .mat_b_i    (b_in),
    .mat_c_i    (c0_in),
    .busy_o     (busy),
    .done_o     (done),
    .mat_c_o    (c_out),
    .ovf_o      (ovf)
  );

  always #(CLK_NS/2) clk = ~clk;

  // Reference: exact-width sums, overflow when the exact value leaves the BUS_WIDTH range.
  task automatic model(input int n, input int k, input int m, input bit mode);
    logic signed [BUS_WIDTH-1:0] acc;
    logic signed [BUS_WIDTH+1:0] exact;
    exp_c   = '0;
    exp_ovf = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < m; j++) begin
        acc = mode ? $signed(c0_in[i][j]) : '0;
        for (int kk = 0; kk < k; kk++) begin
          exact = acc + $signed(a_in[i][kk]) * $signed(b_in[kk][j]);
          if (exact[BUS_WIDTH+1:BUS_WIDTH-1] != 3'b000 && exact[BUS_WIDTH+1:BUS_WIDTH-1] != 3'b111)
            exp_ovf[i*MAX_DIM+j] = 1'b1;
          acc = exact[BUS_WIDTH-1:0];
        end
        exp_c[i][j] = acc;
      end
    end
  endtask

  task automatic rand_ops();
    int s;
    for (int i = 0; i < MAX_DIM; i++) begin
      for (int j = 0; j < MAX_DIM; j++) begin
        s = int'($urandom_range(0, 20)) - 10;
        a_in[i][j]  = $urandom_range(0, 1) ? DATA_WIDTH'($urandom) : DATA_WIDTH'(s);
        s = int'($urandom_range(0, 20)) - 10;
        b_in[i][j]  = $urandom_range(0, 1) ? DATA_WIDTH'($urandom) : DATA_WIDTH'(s);
        s = int'($urandom_range(0, 20)) - 10;
        c0_in[i][j] = $urandom_range(0, 1) ? {$urandom, $urandom} : BUS_WIDTH'(longint'(s));
      end
    end
  endtask

  // Drives one job; reports the cycle done was seen (-1 on timeout) and handshake sanity.
  task automatic run_job(input int n, input int k, input int m, input bit mode, input int poke,
                         output int done_cyc, output bit hs_ok);
    @(negedge clk);
    dn = DIM_W'(n - 1);
    dk = DIM_W'(k - 1);
    dm = DIM_W'(m - 1);
    acc_mode = mode;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    hs_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (!busy) hs_ok = 1'b0;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (c == poke) begin
        start = 1'b1;
        rand_ops();
        acc_mode = ~acc_mode;
        dn = '0;
      end
      if (c == poke + 1) start = 1'b0;
    end
    start = 1'b0;
    @(negedge clk);
    if (done || busy) hs_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (RST_CYC) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (c_out !== '0) begin bad++; $display("FAIL reset_c got=%h exp=0", c_out); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_identity();
    int dc; bit hs;
    a_in = '0; b_in = '0; c0_in = '0;
    a_in[0][0] = 32'd1; a_in[1][1] = 32'd1;
    b_in[0][0] = 32'd3; b_in[0][1] = 32'd4; b_in[1][0] = 32'd5; b_in[1][1] = 32'd6;
    model(2, 2, 2, 1'b0);
    run_job(2, 2, 2, 1'b0, -5, dc, hs);
    total++; if (c_out !== exp_c) begin bad++; $display("FAIL identity_c got=%h exp=%h", c_out, exp_c); end
    total++; if (c_out[1][0] !== 64'd5) begin bad++; $display("FAIL identity_c10 got=%0d exp=5", c_out[1][0]); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL identity_ovf got=%b exp=0", ovf); end
    total++; if (dc != 9) begin bad++; $display("FAIL identity_done_cycle got=%0d exp=9", dc); end
    total++; if (!hs) begin bad++; $display("FAIL identity_busy_window got=0 exp=1"); end
  endtask

  task automatic test_small();
    int dc; bit hs;
    rand_ops();
    a_in[0][0] = 32'd2;  a_in[0][1] = -32'sd3;
    b_in[0][0] = 32'd4;  b_in[1][0] = 32'd5;
    model(1, 2, 1, 1'b0);
    run_job(1, 2, 1, 1'b0, -5, dc, hs);
    total++; if (c_out !== exp_c) begin bad++; $display("FAIL small_c got=%h exp=%h", c_out, exp_c); end
    total++; if ($signed(c_out[0][0]) != -64'sd7) begin bad++; $display("FAIL small_c00 got=%0d exp=-7", $signed(c_out[0][0])); end
    total++; if (dc != 3) begin bad++; $display("FAIL small_done_cycle got=%0d exp=3", dc); end
  endtask

  task automatic test_bias();
    int dc; bit hs;
    a_in[0][0] = 32'd1; a_in[0][1] = 32'd2; a_in[1][0] = 32'd3; a_in[1][1] = 32'd4;
    b_in[0][0] = 32'd5; b_in[0][1] = 32'd6; b_in[1][0] = 32'd7; b_in[1][1] = 32'd8;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) c0_in[i][j] = 64'd1;
    model(2, 2, 2, 1'b1);
    run_job(2, 2, 2, 1'b1, -5, dc, hs);
    total++; if (c_out !== exp_c) begin bad++; $display("FAIL bias_c got=%h exp=%h", c_out, exp_c); end
    total++; if (c_out[1][1] !== 64'd51) begin bad++; $display("FAIL bias_c11 got=%0d exp=51", c_out[1][1]); end
  endtask

  task automatic test_overflow();
    int dc; bit hs;
    rand_ops();
    a_in[0][0] = 32'h8000_0000; a_in[0][1] = 32'h8000_0000;
    b_in[0][0] = 32'h8000_0000; b_in[1][0] = 32'h8000_0000;
    model(1, 2, 1, 1'b0);
    run_job(1, 2, 1, 1'b0, -5, dc, hs);
    total++; if (c_out[0][0] !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_wrap got=%h exp=8000000000000000", c_out[0][0]); end
    total++; if (ovf !== exp_ovf || ovf[0] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", ovf, exp_ovf); end
    a_in[0][0] = 32'd1; b_in[0][0] = 32'd1;
    model(1, 1, 1, 1'b0);
    run_job(1, 1, 1, 1'b0, -5, dc, hs);
    total++; if (ovf !== '0) begin bad++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
    total++; if (dc != 2) begin bad++; $display("FAIL min_done_cycle got=%0d exp=2", dc); end
  endtask

  task automatic test_random();
    int dc, n, k, m; bit hs, mode;
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, MAX_DIM); k = $urandom_range(1, MAX_DIM); m = $urandom_range(1, MAX_DIM);
      mode = $urandom_range(0, 1);
      rand_ops();
      model(n, k, m, mode);
      run_job(n, k, m, mode, -5, dc, hs);
      total++; if (c_out !== exp_c) begin bad++; $display("FAIL rand%0d_c got=%h exp=%h", t, c_out, exp_c); end
      total++; if (ovf !== exp_ovf) begin bad++; $display("FAIL rand%0d_ovf got=%b exp=%b", t, ovf, exp_ovf); end
      total++; if (dc != n*k*m + 1) begin bad++; $display("FAIL rand%0d_done_cycle got=%0d exp=%0d", t, dc, n*k*m + 1); end
      total++; if (!hs) begin bad++; $display("FAIL rand%0d_busy_window got=0 exp=1", t); end
    end
  endtask

  task automatic test_ignore_start();
    int dc; bit hs;
    rand_ops();
    model(2, 2, 2, 1'b1);
    run_job(2, 2, 2, 1'b1, 3, dc, hs);
    total++; if (c_out !== exp_c) begin bad++; $display("FAIL ignore_c got=%h exp=%h", c_out, exp_c); end
    total++; if (ovf !== exp_ovf) begin bad++; $display("FAIL ignore_ovf got=%b exp=%b", ovf, exp_ovf); end
    total++; if (dc != 9) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=9", dc); end
  endtask

  task automatic test_reset_midcalc();
    int dc; bit hs, saw_done;
    rand_ops();
    @(negedge clk);
    dn = 1'b1; dk = 1'b1; dm = 1'b1; acc_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=%b%b exp=00", busy, done); end
    total++; if (c_out !== '0) begin bad++; $display("FAIL midrst_c got=%h exp=0", c_out); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL midrst_ovf got=%b exp=0", ovf); end
    saw_done = 1'b0;
    repeat (2) begin @(negedge clk); if (done) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (8) begin @(negedge clk); if (done || busy) saw_done = 1'b1; end
    total++; if (saw_done) begin bad++; $display("FAIL midrst_no_done got=1 exp=0"); end
    model(2, 2, 2, 1'b0);
    run_job(2, 2, 2, 1'b0, -5, dc, hs);
    total++; if (c_out !== exp_c || dc != 9) begin bad++; $display("FAIL midrst_rerun got=%h/%0d exp=%h/9", c_out, dc, exp_c); end
  endtask

  task automatic test_back_to_back();
    int c1, c2; logic idle_busy;
    rand_ops();
    model(1, 2, 1, 1'b1);
    @(negedge clk);
    dn = '0; dk = 1'b1; dm = '0; acc_mode = 1'b1; start = 1'b1;
    @(posedge clk);
    c1 = -1; c2 = -1; idle_busy = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c1 > 0 && c == c1 + 1) idle_busy = busy;
      if (c1 > 0 && c == c1 + 2) start = 1'b0;
      if (done) begin
        if (c1 < 0) c1 = c;
        else begin c2 = c; break; end
      end
    end
    start = 1'b0;
    total++; if (c1 != 3) begin bad++; $display("FAIL b2b_first_done got=%0d exp=3", c1); end
    total++; if (idle_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got=%b exp=0", idle_busy); end
    total++; if (c2 != 7) begin bad++; $display("FAIL b2b_second_done got=%0d exp=7", c2); end
    total++; if (c_out !== exp_c) begin bad++; $display("FAIL b2b_c got=%h exp=%h", c_out, exp_c); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_small();
    test_bias();
    test_overflow();
    test_random();
    test_ignore_start();
    test_reset_midcalc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
